// File: rtl/key_expansion_ctrl_if.sv
// Key-load and round-key stream bundle between the key loader / cipher core
// (master) and the key expansion sequencer (slave).
interface key_expansion_ctrl_if;
  logic         start;
  logic [255:0] key_in;
  logic         abort;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         busy;
  logic         done;

  modport master (
    output start, key_in, abort, rk_ready,
    input  rk_valid, rk_data, rk_idx, busy, done
  );

  modport slave (
    input  start, key_in, abort, rk_ready,
    output rk_valid, rk_data, rk_idx, busy, done
  );
endinterface

// File: rtl/key_expansion_ctrl.sv
// AES-256 key expansion sequencer: steps an external Keyschedule through
// rc = 1..13 and streams rk0..rk14 over a valid/ready handshake.
module key_expansion_ctrl (
  input  logic                       clk,
  input  logic                       rst,
  key_expansion_ctrl_if.slave        bus,
  output logic [3:0]                 ks_rc,
  output logic [127:0]               ks_srcup,
  output logic [127:0]               ks_srclo,
  input  logic [127:0]               ks_keyoutup,
  input  logic [127:0]               ks_keyoutlo
);

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    ISSUE,
    CAPTURE
  } state_t;

  state_t       state_reg;
  logic [127:0] up_reg;
  logic [127:0] lo_reg;
  logic [127:0] data_reg;
  logic [3:0]   rc_reg;
  logic [3:0]   idx_reg;
  logic         valid_reg;
  logic         busy_reg;
  logic         done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      up_reg    <= '0;
      lo_reg    <= '0;
      data_reg  <= '0;
      rc_reg    <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            up_reg    <= bus.key_in[255:128];
            lo_reg    <= bus.key_in[127:0];
            data_reg  <= bus.key_in[255:128];
            idx_reg   <= 4'd0;
            rc_reg    <= 4'd0;
            state_reg <= EMIT;
            valid_reg <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end

        EMIT: begin
          // abort wins over a same-cycle handshake: that key is not transferred
          if (bus.abort) begin
            state_reg <= IDLE;
            rc_reg    <= 4'd0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
          end else if (bus.rk_ready) begin
            if (idx_reg == 4'd14) begin
              state_reg <= IDLE;
              rc_reg    <= 4'd0;
              valid_reg <= 1'b0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else if (idx_reg == 4'd0) begin
              idx_reg  <= 4'd1;
              data_reg <= lo_reg;
            end else begin
              rc_reg    <= idx_reg;
              state_reg <= ISSUE;
              valid_reg <= 1'b0;
            end
          end
        end

        ISSUE: begin
          if (bus.abort) begin
            state_reg <= IDLE;
            rc_reg    <= 4'd0;
            busy_reg  <= 1'b0;
          end else begin
            state_reg <= CAPTURE;
          end
        end

        CAPTURE: begin
          if (bus.abort) begin
            state_reg <= IDLE;
            rc_reg    <= 4'd0;
            busy_reg  <= 1'b0;
          end else begin
            // odd rc refreshes the upper half, even rc the lower half
            if (rc_reg[0]) begin
              up_reg   <= ks_keyoutup;
              data_reg <= ks_keyoutup;
            end else begin
              lo_reg   <= ks_keyoutlo;
              data_reg <= ks_keyoutlo;
            end
            idx_reg   <= rc_reg + 4'd1;
            state_reg <= EMIT;
            valid_reg <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          rc_reg    <= 4'd0;
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rk_valid = valid_reg;
  assign bus.rk_data  = data_reg;
  assign bus.rk_idx   = idx_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign ks_rc        = rc_reg;
  assign ks_srcup     = up_reg;
  assign ks_srclo     = lo_reg;

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Bench for key_expansion_ctrl with a behavioural AES-256 Keyschedule stage
// and a word-based reference key expansion.
module tb_key_expansion_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   ks_rc;
  logic [127:0] ks_srcup;
  logic [127:0] ks_srclo;
  logic [127:0] ks_keyoutup;
  logic [127:0] ks_keyoutlo;

  key_expansion_ctrl_if bus ();

  key_expansion_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .ks_rc       (ks_rc),
    .ks_srcup    (ks_srcup),
    .ks_srclo    (ks_srclo),
    .ks_keyoutup (ks_keyoutup),
    .ks_keyoutlo (ks_keyoutlo)
  );

  always #5 clk = ~clk;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] subw(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = SBOX[2047 - 8*int'(w[8*b +: 8]) -: 8];
    return r;
  endfunction

  function automatic logic [31:0] rotw(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [127:0] chain(input logic [127:0] h, input logic [31:0] t);
    logic [31:0] w0, w1, w2, w3;
    w0 = h[127:96] ^ t;
    w1 = h[95:64] ^ w0;
    w2 = h[63:32] ^ w1;
    w3 = h[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Keyschedule stage: registered half-key update selected by rc parity
  always_ff @(posedge clk) begin
    if (ks_rc != 4'd0) begin
      if (ks_rc[0])
        ks_keyoutup <= chain(ks_srcup, subw(rotw(ks_srclo[31:0])) ^ {8'h01 << ((ks_rc - 4'd1) >> 1), 24'h0});
      else
        ks_keyoutlo <= chain(ks_srclo, subw(ks_srcup[31:0]));
    end
  end

  typedef struct {
    logic [255:0] key;
    int           idx;
    logic [127:0] rk;
  } vec_t;

  localparam logic [255:0] KEY_C3   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_ZERO = 256'h0;

  vec_t         vecs [8];
  logic [255:0] keys [2];
  logic [127:0] ref_rk [15];
  logic [127:0] got_rk [15];
  int           pass_cnt = 0;
  int           total_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic build_ref(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) t = subw(rotw(t)) ^ {8'h01 << (i/8 - 1), 24'h0};
      else if (i % 8 == 4) t = subw(t);
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check_idle_reset(input string tag);
    chk({tag, "_valid"},   128'(bus.rk_valid), 128'd0);
    chk({tag, "_busy"},    128'(bus.busy),     128'd0);
    chk({tag, "_done"},    128'(bus.done),     128'd0);
    chk({tag, "_idx"},     128'(bus.rk_idx),   128'd0);
    chk({tag, "_data"},    bus.rk_data,        128'd0);
    chk({tag, "_ks_rc"},   128'(ks_rc),        128'd0);
    chk({tag, "_srcup"},   ks_srcup,           128'd0);
    chk({tag, "_srclo"},   ks_srclo,           128'd0);
  endtask

  // mode 0: rk_ready high; mode 1: pseudo-random rk_ready
  task automatic run(input logic [255:0] key, input int mode, input int abort_idx,
                     input int spur_idx, input int rst_idx, input string tag);
    int           exp_idx = 0;
    int           done_cyc = -1;
    bit           stalled = 0;
    bit           ended = 0;
    bit           cut = 0;
    logic [127:0] held_data = '0;
    logic [3:0]   held_idx = '0;
    logic [7:0]   lfsr = 8'ha5;
    build_ref(key);
    for (int i = 0; i < 15; i++) got_rk[i] = '0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.key_in = key;
    for (int cyc = 1; cyc < 400 && !ended; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      bus.rk_ready = (mode == 0) ? 1'b1 : lfsr[0];
      if (bus.done) begin
        done_cyc = cyc;
        ended = 1;
      end else if (bus.rk_valid) begin
        if (stalled) begin
          chk({tag, "_stall_data"}, bus.rk_data, held_data);
          chk({tag, "_stall_idx"}, 128'(bus.rk_idx), 128'(held_idx));
        end
        if (int'(bus.rk_idx) == abort_idx) begin
          bus.abort = 1'b1;
          bus.rk_ready = 1'b1;
          @(negedge clk);
          bus.abort = 1'b0;
          chk({tag, "_abort_busy"},  128'(bus.busy),     128'd0);
          chk({tag, "_abort_valid"}, 128'(bus.rk_valid), 128'd0);
          chk({tag, "_abort_done"},  128'(bus.done),     128'd0);
          @(negedge clk);
          chk({tag, "_abort_done2"}, 128'(bus.done),     128'd0);
          ended = 1;
          cut = 1;
        end else begin
          if (int'(bus.rk_idx) == spur_idx) begin
            bus.start  = 1'b1;
            bus.key_in = ~key;
          end
          if (bus.rk_ready) begin
            chk($sformatf("%s_idx%0d", tag, exp_idx), 128'(bus.rk_idx), 128'(exp_idx));
            chk($sformatf("%s_rk%0d", tag, exp_idx), bus.rk_data, ref_rk[exp_idx % 15]);
            if (mode == 0)
              chk($sformatf("%s_cyc%0d", tag, exp_idx), 128'(cyc),
                  128'((exp_idx == 0) ? 1 : 2 + 3 * (exp_idx - 1)));
            if (exp_idx < 15) got_rk[exp_idx] = bus.rk_data;
            exp_idx++;
            stalled = 0;
            if (int'(bus.rk_idx) == rst_idx) begin
              @(negedge clk);
              chk({tag, "_issue_rc"}, 128'(ks_rc), 128'(rst_idx));
              chk({tag, "_issue_valid"}, 128'(bus.rk_valid), 128'd0);
              @(negedge clk);
              chk({tag, "_capture_rc"}, 128'(ks_rc), 128'(rst_idx));
              rst = 1'b1;
              @(negedge clk);
              rst = 1'b0;
              check_idle_reset({tag, "_rst"});
              ended = 1;
              cut = 1;
            end
          end else begin
            stalled = 1;
            held_data = bus.rk_data;
            held_idx = bus.rk_idx;
          end
        end
      end else if (stalled) begin
        chk({tag, "_valid_dropped"}, 128'd0, 128'd1);
        stalled = 0;
      end
    end
    if (!cut) begin
      chk({tag, "_count"}, 128'(exp_idx), 128'd15);
      if (mode == 0) chk({tag, "_done_cyc"}, 128'(done_cyc), 128'd42);
      else chk({tag, "_done_seen"}, 128'(done_cyc > 0), 128'd1);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 128'(bus.done), 128'd0);
      chk({tag, "_idle_busy"},  128'(bus.busy), 128'd0);
      chk({tag, "_idle_rc"},    128'(ks_rc),    128'd0);
    end
    bus.rk_ready = 1'b0;
    $display("run %s: %0d keys accepted, done at cycle %0d", tag, exp_idx, done_cyc);
  endtask

  initial begin
    vecs[0] = '{KEY_C3,    0, 128'h000102030405060708090a0b0c0d0e0f};
    vecs[1] = '{KEY_C3,    1, 128'h101112131415161718191a1b1c1d1e1f};
    vecs[2] = '{KEY_C3,    2, 128'ha573c29fa176c498a97fce93a572c09c};
    vecs[3] = '{KEY_C3,    3, 128'h1651a8cd0244beda1a5da4c10640bade};
    vecs[4] = '{KEY_C3,   14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
    vecs[5] = '{KEY_ZERO,  0, 128'h0};
    vecs[6] = '{KEY_ZERO,  2, 128'h62636363626363636263636362636363};
    vecs[7] = '{KEY_ZERO,  3, 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb};
    keys[0] = KEY_C3;
    keys[1] = KEY_ZERO;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.rk_ready = 1'b0;
    bus.key_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle_reset("reset");

    for (int k = 0; k < 2; k++) begin
      run(keys[k], 0, -1, -1, -1, $sformatf("key%0d", k));
      for (int v = 0; v < 8; v++)
        if (vecs[v].key == keys[k])
          chk($sformatf("vec%0d_rk%0d", v, vecs[v].idx), got_rk[vecs[v].idx], vecs[v].rk);
    end

    run(KEY_C3, 1, -1, -1, -1, "stall");
    run(KEY_C3, 0, 7, -1, -1, "abort");
    run(KEY_C3, 0, -1, -1, -1, "post_abort");
    run(KEY_C3, 0, -1, -1, 5, "midrst");
    run(KEY_C3, 0, -1, -1, -1, "post_rst");
    run(KEY_C3, 0, -1, 3, -1, "spur_start");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
